// File: rtl/run_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with per-phase strobes,
// halt/resume, single-step and a memory-wait timeout that parks the core in HALTED with fault.
module run_control #(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 step,
   input  logic                 resume,
   input  logic                 halt_signal,
   input  logic                 is_mem,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_is_data,
   output logic                 ir_load,
   output logic                 reg_we,
   output logic                 pc_en,
   output logic                 running,
   output logic                 program_halted,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALTED = 3'd6
   } state_t;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t            state, state_next;
   logic              step_mode, step_mode_next;
   logic              mem_op, mem_op_next;
   logic              fault_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              timed_out;

   // A memory phase is "waiting" when it is stalled on mem_ready.
   assign waiting   = (state == FETCH || state == MEM) && !mem_ready;
   assign timed_out = waiting && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         step_mode   <= 1'b0;
         mem_op      <= 1'b0;
         fault       <= 1'b0;
         wait_cnt    <= '0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         state     <= state_next;
         step_mode <= step_mode_next;
         mem_op    <= mem_op_next;
         fault     <= fault_next;
         if (waiting && state_next == state)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (running && cycle_count != '1)
            cycle_count <= cycle_count + CNT_ONE;
         if (state == WB && instr_count != '1)
            instr_count <= instr_count + CNT_ONE;
      end
   end

   always_comb begin
      state_next     = state;
      step_mode_next = step_mode;
      mem_op_next    = mem_op;
      fault_next     = fault;
      mem_req        = 1'b0;
      mem_is_data    = 1'b0;
      ir_load        = 1'b0;
      reg_we         = 1'b0;
      pc_en          = 1'b0;
      running        = 1'b0;
      program_halted = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next     = FETCH;
               step_mode_next = 1'b0;
            end else if (step) begin
               state_next     = FETCH;
               step_mode_next = 1'b1;
            end
         end
         FETCH: begin
            running = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load    = 1'b1;
               state_next = DECODE;
            end else if (timed_out) begin
               state_next = HALTED;
               fault_next = 1'b1;
            end
         end
         DECODE: begin
            running = 1'b1;
            if (halt_signal) begin
               state_next = HALTED;
            end else begin
               mem_op_next = is_mem;
               state_next  = EXEC;
            end
         end
         EXEC: begin
            running    = 1'b1;
            state_next = mem_op ? MEM : WB;
         end
         MEM: begin
            running     = 1'b1;
            mem_req     = 1'b1;
            mem_is_data = 1'b1;
            if (mem_ready) begin
               state_next = WB;
            end else if (timed_out) begin
               state_next = HALTED;
               fault_next = 1'b1;
            end
         end
         WB: begin
            running    = 1'b1;
            reg_we     = 1'b1;
            pc_en      = 1'b1;
            state_next = step_mode ? IDLE : FETCH;
         end
         HALTED: begin
            program_halted = 1'b1;
            if (resume) begin
               state_next = IDLE;
               fault_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_run_control.sv
// Cycle-accurate bench for run_control: per-cycle expected strobe vectors go through a
// scoreboard queue; counters and the asynchronous reset abort are checked by hand.
module tb_run_control;

   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, step, resume, halt_signal, is_mem, mem_ready;
   logic          mem_req, mem_is_data, ir_load, reg_we, pc_en, running, program_halted, fault;
   logic [CW-1:0] cycle_count, instr_count;
   logic [2:0]    state_dbg;

   // Output vector order: mem_req mem_is_data ir_load reg_we pc_en running program_halted fault
   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_FETCH = 8'b1010_0100;
   localparam logic [7:0] O_RUN   = 8'b0000_0100;
   localparam logic [7:0] O_MEM   = 8'b1100_0100;
   localparam logic [7:0] O_WB    = 8'b0001_1100;
   localparam logic [7:0] O_HALT  = 8'b0000_0010;
   localparam logic [7:0] O_FAULT = 8'b0000_0011;

   typedef struct packed {
      logic       start;
      logic       step;
      logic       resume;
      logic       halt_sig;
      logic       is_mem;
      logic       ready;
      logic [7:0] exp;
   } vec_t;

   logic [7:0] exp_q[$];
   int         tests  = 0;
   int         failed = 0;

   run_control #(.CNT_WIDTH(CW), .MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .step(step), .resume(resume),
      .halt_signal(halt_signal), .is_mem(is_mem), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_is_data(mem_is_data), .ir_load(ir_load),
      .reg_we(reg_we), .pc_en(pc_en), .running(running),
      .program_halted(program_halted), .fault(fault),
      .cycle_count(cycle_count), .instr_count(instr_count), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic st, input logic sp, input logic rs, input logic hs,
                               input logic im, input logic rd, input logic [7:0] e);
      vec_t v;
      v.start = st; v.step = sp; v.resume = rs; v.halt_sig = hs;
      v.is_mem = im; v.ready = rd; v.exp = e;
      return v;
   endfunction

   // Called just after a rising edge; drives one cycle, checks at the falling edge.
   task automatic apply(input vec_t v, input string tag);
      logic [7:0] got, e;
      start = v.start; step = v.step; resume = v.resume;
      halt_signal = v.halt_sig; is_mem = v.is_mem; mem_ready = v.ready;
      exp_q.push_back(v.exp);
      @(negedge clk);
      got = {mem_req, mem_is_data, ir_load, reg_we, pc_en, running, program_halted, fault};
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
         failed++;
         $display("FAIL %s: outputs=%b expected=%b", tag, got, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] e);
      tests++;
      if (act !== e) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", tag, act, e);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      start = 0; step = 0; resume = 0; halt_signal = 0; is_mem = 0; mem_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Free-running non-mem instruction with zero-wait memory: 4-cycle pattern.
   function automatic logic [7:0] run_exp(input int k);
      case ((k - 1) % 4)
         0:       return O_FETCH;
         3:       return O_WB;
         default: return O_RUN;
      endcase
   endfunction

   vec_t tbl_step[7];
   vec_t tbl_both[8];

   initial begin
      // step with a memory instruction, zero-wait memory
      tbl_step[0] = mk(0, 1, 0, 0, 0, 0, O_IDLE);
      tbl_step[1] = mk(0, 0, 0, 0, 0, 1, O_FETCH);
      tbl_step[2] = mk(0, 0, 0, 0, 1, 1, O_RUN);
      tbl_step[3] = mk(0, 0, 0, 0, 0, 1, O_RUN);
      tbl_step[4] = mk(0, 0, 0, 0, 0, 1, O_MEM);
      tbl_step[5] = mk(0, 0, 0, 0, 0, 1, O_WB);
      tbl_step[6] = mk(0, 0, 0, 0, 0, 1, O_IDLE);
      // start+step together selects run mode: WB is followed by FETCH, not IDLE
      tbl_both[0] = mk(1, 1, 0, 0, 0, 0, O_IDLE);
      tbl_both[1] = mk(0, 0, 0, 0, 0, 1, O_FETCH);
      tbl_both[2] = mk(0, 0, 0, 0, 0, 1, O_RUN);
      tbl_both[3] = mk(0, 0, 0, 0, 0, 1, O_RUN);
      tbl_both[4] = mk(0, 0, 0, 0, 0, 1, O_WB);
      tbl_both[5] = mk(0, 0, 0, 0, 0, 1, O_FETCH);
      tbl_both[6] = mk(0, 0, 0, 0, 1, 1, O_RUN);
      tbl_both[7] = mk(0, 0, 0, 0, 0, 0, O_RUN);

      // reset, then idle with no inputs
      do_reset();
      for (int i = 0; i < 10; i++) begin
         apply(mk(0, 0, 0, 0, 0, $urandom_range(0, 1), O_IDLE), $sformatf("idle[%0d]", i));
         check_val("idle_cycles", cycle_count, 0);
         check_val("idle_instrs", instr_count, 0);
      end

      // single step of a memory instruction
      for (int i = 0; i < 7; i++) apply(tbl_step[i], $sformatf("step[%0d]", i));
      check_val("step_instrs", instr_count, 1);
      check_val("step_cycles", cycle_count, 5);

      // free run, 20 running cycles
      do_reset();
      apply(mk(1, 0, 0, 0, 0, 1, O_IDLE), "run_start");
      for (int k = 1; k <= 20; k++) apply(mk(0, 0, 0, 0, 0, 1, run_exp(k)), $sformatf("run[%0d]", k));
      check_val("run_instrs", instr_count, 5);
      check_val("run_cycles", cycle_count, 20);

      // halt in DECODE of the 3rd instruction, start/step ignored while halted, then resume
      do_reset();
      apply(mk(1, 0, 0, 0, 0, 1, O_IDLE), "halt_start");
      for (int k = 1; k <= 9; k++) apply(mk(0, 0, 0, 0, 0, 1, run_exp(k)), $sformatf("halt_run[%0d]", k));
      apply(mk(0, 0, 0, 1, 0, 1, O_RUN), "halt_decode");
      apply(mk(1, 1, 0, 0, 0, 1, O_HALT), "halted_ignore");
      apply(mk(0, 0, 1, 0, 0, 1, O_HALT), "halted_resume");
      apply(mk(0, 0, 0, 0, 0, 1, O_IDLE), "after_resume");
      check_val("halt_instrs", instr_count, 2);
      check_val("halt_cycles", cycle_count, 10);

      // memory timeout: 16 wait cycles in MEM -> fault
      do_reset();
      apply(mk(0, 1, 0, 0, 0, 0, O_IDLE), "to_step");
      apply(mk(0, 0, 0, 0, 0, 1, O_FETCH), "to_fetch");
      apply(mk(0, 0, 0, 0, 1, 0, O_RUN), "to_decode");
      apply(mk(0, 0, 0, 0, 0, 0, O_RUN), "to_exec");
      for (int w = 1; w <= 16; w++) apply(mk(0, 0, 0, 0, 0, 0, O_MEM), $sformatf("to_wait[%0d]", w));
      apply(mk(0, 0, 0, 0, 0, 0, O_FAULT), "to_fault");
      apply(mk(0, 0, 1, 0, 0, 0, O_FAULT), "to_resume");
      apply(mk(0, 0, 0, 0, 0, 0, O_IDLE), "to_idle");
      check_val("to_instrs", instr_count, 0);
      check_val("to_cycles", cycle_count, 19);

      // ready arriving on the 16th wait cycle completes normally
      apply(mk(0, 1, 0, 0, 0, 0, O_IDLE), "dl_step");
      apply(mk(0, 0, 0, 0, 0, 1, O_FETCH), "dl_fetch");
      apply(mk(0, 0, 0, 0, 1, 0, O_RUN), "dl_decode");
      apply(mk(0, 0, 0, 0, 0, 0, O_RUN), "dl_exec");
      for (int w = 1; w <= 15; w++) apply(mk(0, 0, 0, 0, 0, 0, O_MEM), $sformatf("dl_wait[%0d]", w));
      apply(mk(0, 0, 0, 0, 0, 1, O_MEM), "dl_ready16");
      apply(mk(0, 0, 0, 0, 0, 0, O_WB), "dl_wb");
      apply(mk(0, 0, 0, 0, 0, 0, O_IDLE), "dl_idle");
      check_val("dl_instrs", instr_count, 1);
      check_val("dl_cycles", cycle_count, 39);

      // start+step together, then asynchronous reset in the middle of MEM
      do_reset();
      for (int i = 0; i < 8; i++) apply(tbl_both[i], $sformatf("both[%0d]", i));
      mem_ready = 1'b0;
      @(negedge clk);
      check_val("mid_mem_req", {31'd0, mem_req}, 1);
      rst = 1'b0;
      #1;
      check_val("abort_mem_req", {31'd0, mem_req}, 0);
      check_val("abort_running", {31'd0, running}, 0);
      check_val("abort_cycles", cycle_count, 0);
      check_val("abort_instrs", instr_count, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 1, O_IDLE), "post_abort_idle");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
